// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch sequencer in front of instr_dec. Owns the program counter,
// reads the opcode word from ROM, works out how many extension words follow
// from the addressing-mode fields, fetches them, and presents one complete
// byte-swapped bundle to the decoder. The bundle is held until the decoder
// takes it.
//
// Handshake: instr_valid is high only in HOLD. A bundle is consumed on a rising
// edge where instr_valid=1 and stall=0. While stall=1 in HOLD, every output
// holds. pc_load has priority over everything else in every state. A pc_load on
// a consuming edge still consumes the held bundle, and the redirect also applies.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   pc_load      redirect request
//   pc_load_val  redirect target (bit 0 ignored)
//   stall        decoder not ready (sampled only in HOLD)
//   MDB_out      ROM data for MAB_out, same cycle, low byte first
//   MAB_out      ROM address (the PC register)
//   reg_PC_out   current fetch PC (the PC register)
//   instr_valid  bundle complete and held
//   instr        opcode word, byte-swapped
//   ext1, ext2   extension words, byte-swapped, 0 when unused
//   instr_len    bundle length in words (1..3)
//   instr_addr   address of the opcode word
//   dbg_state    FSM state: 0 FETCH_OP, 1 FETCH_EXT1, 2 FETCH_EXT2, 3 HOLD
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [15:0] RESET_PC = 16'hC000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_load,
   input  logic [15:0] pc_load_val,
   input  logic        stall,
   input  logic [15:0] MDB_out,
   output logic [15:0] MAB_out,
   output logic [15:0] reg_PC_out,
   output logic        instr_valid,
   output logic [15:0] instr,
   output logic [15:0] ext1,
   output logic [15:0] ext2,
   output logic [1:0]  instr_len,
   output logic [15:0] instr_addr,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      FETCH_OP   = 2'd0,
      FETCH_EXT1 = 2'd1,
      FETCH_EXT2 = 2'd2,
      HOLD       = 2'd3
   } state_t;

   state_t      r_state;
   logic [15:0] r_pc;
   logic        r_valid;
   logic [15:0] r_instr;
   logic [15:0] r_ext1;
   logic [15:0] r_ext2;
   logic [1:0]  r_len;
   logic [15:0] r_addr;

   logic [15:0] w_word;
   logic [15:0] w_pc_next;
   logic        w_fmt1;
   logic        w_fmt2;
   logic [1:0]  w_as;
   logic [3:0]  w_src;
   logic        w_src_ext;
   logic        w_dst_ext;
   logic [1:0]  w_len;

   // ROM delivers the low byte first; the decoder wants the natural word.
   assign w_word    = {MDB_out[7:0], MDB_out[15:8]};
   assign w_pc_next = r_pc + 16'd2;

   // Jumps (001x) and unassigned encodings match neither format and fall out
   // as length 1 without a dedicated decode.
   assign w_fmt2 = (w_word[15:12] == 4'b0001);
   assign w_fmt1 = (w_word[15:12] >= 4'b0100);
   assign w_as   = w_word[5:4];
   assign w_src  = w_fmt2 ? w_word[3:0] : w_word[11:8];

   // Source word: indexed/symbolic/absolute (As=01, not CG2) or immediate
   // (@PC+). R3 with any As and R2 with As=1x are constant-generator forms.
   assign w_src_ext = (w_fmt1 | w_fmt2) &
                      (((w_as == 2'b01) && (w_src != 4'd3)) ||
                       ((w_as == 2'b11) && (w_src == 4'd0)));
   assign w_dst_ext = w_fmt1 & w_word[7];
   assign w_len     = 2'd1 + {1'b0, w_src_ext} + {1'b0, w_dst_ext};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FETCH_OP;
         r_pc    <= RESET_PC;
         r_valid <= 1'b0;
         r_instr <= 16'h0000;
         r_ext1  <= 16'h0000;
         r_ext2  <= 16'h0000;
         r_len   <= 2'd1;
         r_addr  <= 16'h0000;
      end else if (pc_load) begin
         // Redirect discards any partial or held bundle.
         r_state <= FETCH_OP;
         r_pc    <= pc_load_val & 16'hFFFE;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            FETCH_OP: begin
               r_instr <= w_word;
               r_addr  <= r_pc;
               r_ext1  <= 16'h0000;
               r_ext2  <= 16'h0000;
               r_len   <= w_len;
               r_pc    <= w_pc_next;
               if (w_len == 2'd1) begin
                  r_state <= HOLD;
                  r_valid <= 1'b1;
               end else begin
                  r_state <= FETCH_EXT1;
               end
            end
            FETCH_EXT1: begin
               r_ext1 <= w_word;
               r_pc   <= w_pc_next;
               if (r_len == 2'd3) begin
                  r_state <= FETCH_EXT2;
               end else begin
                  r_state <= HOLD;
                  r_valid <= 1'b1;
               end
            end
            FETCH_EXT2: begin
               r_ext2  <= w_word;
               r_pc    <= w_pc_next;
               r_state <= HOLD;
               r_valid <= 1'b1;
            end
            HOLD: begin
               // PC already points past the bundle; it stays put here.
               if (!stall) begin
                  r_state <= FETCH_OP;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= FETCH_OP;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign MAB_out     = r_pc;
   assign reg_PC_out  = r_pc;
   assign instr_valid = r_valid;
   assign instr       = r_instr;
   assign ext1        = r_ext1;
   assign ext2        = r_ext2;
   assign instr_len   = r_len;
   assign instr_addr  = r_addr;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. A word-addressed ROM array answers MAB_out
// combinationally. Expected bundles are queued before each fetch and popped
// when instr_valid is seen; all outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   localparam int W = 66;   // {instr, ext1, ext2, len[1:0], addr}

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_load;
   logic [15:0] pc_load_val;
   logic        stall;
   logic [15:0] mdb;
   logic [15:0] mab;
   logic [15:0] pc;
   logic        instr_valid;
   logic [15:0] instr;
   logic [15:0] ext1;
   logic [15:0] ext2;
   logic [1:0]  instr_len;
   logic [15:0] instr_addr;
   logic [1:0]  dbg_state;

   logic [15:0] rom [0:32767];
   logic [W-1:0] exp_q[$];
   int n_assert = 0;
   int n_fail   = 0;

   instr_fetch #(.RESET_PC(16'hC000)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_load     (pc_load),
      .pc_load_val (pc_load_val),
      .stall       (stall),
      .MDB_out     (mdb),
      .MAB_out     (mab),
      .reg_PC_out  (pc),
      .instr_valid (instr_valid),
      .instr       (instr),
      .ext1        (ext1),
      .ext2        (ext2),
      .instr_len   (instr_len),
      .instr_addr  (instr_addr),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   assign mdb = rom[mab[15:1]];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [15:0] addr, input logic [15:0] data);
      rom[addr[15:1]] = data;
   endtask

   task automatic push_bundle(input logic [15:0] i, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [1:0] len,
                              input logic [15:0] addr);
      exp_q.push_back({i, e1, e2, len, addr});
   endtask

   task automatic check_reset(input string tag);
      check($sformatf("%s pc", tag),    pc,         16'hC000);
      check($sformatf("%s mab", tag),   mab,        16'hC000);
      check($sformatf("%s valid", tag), {15'd0, instr_valid}, 16'd0);
      check($sformatf("%s instr", tag), instr,      16'h0000);
      check($sformatf("%s ext1", tag),  ext1,       16'h0000);
      check($sformatf("%s ext2", tag),  ext2,       16'h0000);
      check($sformatf("%s addr", tag),  instr_addr, 16'h0000);
      check($sformatf("%s len", tag),   {14'd0, instr_len}, 16'd1);
      check($sformatf("%s state", tag), {14'd0, dbg_state}, 16'd0);
   endtask

   // Waits (bounded) for instr_valid, checks the cycle count, then compares
   // the bundle with the oldest queued expectation.
   task automatic wait_bundle(input string tag, input int exp_lat);
      int cyc;
      logic [W-1:0] e;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!instr_valid && cyc < 12);
      check($sformatf("%s latency", tag), 16'(cyc), 16'(exp_lat));
      check($sformatf("%s queued", tag), {15'd0, exp_q.size() != 0}, 16'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check($sformatf("%s instr", tag), instr,      e[65:50]);
         check($sformatf("%s ext1", tag),  ext1,       e[49:34]);
         check($sformatf("%s ext2", tag),  ext2,       e[33:18]);
         check($sformatf("%s len", tag),   {14'd0, instr_len}, {14'd0, e[17:16]});
         check($sformatf("%s addr", tag),  instr_addr, e[15:0]);
      end
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
      put(16'hC000, 16'h0645);   // MOV R5,R6
      put(16'hC002, 16'h3640);   // MOV #0x1234,R6
      put(16'hC004, 16'h3412);
      put(16'hC006, 16'h9242);   // MOV &0x0200,&0x0202
      put(16'hC008, 16'h0002);
      put(16'hC00A, 16'h0202);
      put(16'hC00C, 16'h1643);   // MOV #1,R6 (constant generator)
      put(16'hC00E, 16'h003C);   // JMP
      put(16'hC010, 16'h0645);
      put(16'hC012, 16'h3640);   // redirected away during its extension fetch
      put(16'hC014, 16'h3412);
      put(16'hE000, 16'h9242);
      put(16'hE002, 16'h0002);
      put(16'hE004, 16'h0202);
      put(16'hE100, 16'h0645);
      put(16'hFFFE, 16'h3640);   // extension wraps to 0x0000
      put(16'h0000, 16'h3412);

      rst = 1'b1;
      pc_load = 1'b0;
      pc_load_val = 16'h0000;
      stall = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("reset");

      rst = 1'b0;
      push_bundle(16'h4506, 16'h0000, 16'h0000, 2'd1, 16'hC000);
      wait_bundle("mov_reg", 1);
      @(negedge clk);
      check("consumed pc",    pc, 16'hC002);
      check("consumed state", {14'd0, dbg_state}, 16'd0);
      check("consumed valid", {15'd0, instr_valid}, 16'd0);

      push_bundle(16'h4036, 16'h1234, 16'h0000, 2'd2, 16'hC002);
      wait_bundle("mov_imm", 2);
      check("mov_imm pc", pc, 16'hC006);

      push_bundle(16'h4292, 16'h0200, 16'h0202, 2'd3, 16'hC006);
      wait_bundle("mov_abs", 4);
      push_bundle(16'h4316, 16'h0000, 16'h0000, 2'd1, 16'hC00C);
      wait_bundle("mov_cg", 2);
      push_bundle(16'h3C00, 16'h0000, 16'h0000, 2'd1, 16'hC00E);
      wait_bundle("jmp", 2);

      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall valid", {15'd0, instr_valid}, 16'd1);
         check("stall pc",    pc,    16'hC010);
         check("stall instr", instr, 16'h3C00);
         check("stall state", {14'd0, dbg_state}, 16'd3);
      end
      check("stall addr", instr_addr, 16'hC00E);
      check("stall len",  {14'd0, instr_len}, 16'd1);
      stall = 1'b0;
      push_bundle(16'h4506, 16'h0000, 16'h0000, 2'd1, 16'hC010);
      wait_bundle("after_stall", 2);

      @(negedge clk);
      check("pre_redir state", {14'd0, dbg_state}, 16'd0);
      @(negedge clk);
      check("ext1 state", {14'd0, dbg_state}, 16'd1);
      check("ext1 pc",    pc, 16'hC014);
      pc_load = 1'b1;
      pc_load_val = 16'hE001;
      @(negedge clk);
      pc_load = 1'b0;
      check("redir pc",    pc, 16'hE000);
      check("redir valid", {15'd0, instr_valid}, 16'd0);
      check("redir state", {14'd0, dbg_state}, 16'd0);
      push_bundle(16'h4292, 16'h0200, 16'h0202, 2'd3, 16'hE000);
      wait_bundle("redir", 3);

      pc_load = 1'b1;
      pc_load_val = 16'hE100;
      @(negedge clk);
      pc_load = 1'b0;
      check("consume_redir valid", {15'd0, instr_valid}, 16'd0);
      check("consume_redir pc",    pc, 16'hE100);
      push_bundle(16'h4506, 16'h0000, 16'h0000, 2'd1, 16'hE100);
      wait_bundle("consume_redir", 1);

      pc_load = 1'b1;
      pc_load_val = 16'hFFFE;
      @(negedge clk);
      pc_load = 1'b0;
      push_bundle(16'h4036, 16'h1234, 16'h0000, 2'd2, 16'hFFFE);
      wait_bundle("wrap", 2);
      check("wrap pc", pc, 16'h0002);

      pc_load = 1'b1;
      pc_load_val = 16'hFFFE;
      @(negedge clk);
      pc_load = 1'b0;
      @(negedge clk);
      check("pre_rst state", {14'd0, dbg_state}, 16'd1);
      #1 rst = 1'b1;
      #1 check_reset("async_reset");
      @(negedge clk);
      rst = 1'b0;
      push_bundle(16'h4506, 16'h0000, 16'h0000, 2'd1, 16'hC000);
      wait_bundle("after_reset", 1);

      check("queue empty", 16'(exp_q.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer sitting directly upstream of `instr_dec`. It owns the program counter, drives the ROM address, reads the opcode word, computes the instruction length (1–3 words) from its addressing-mode fields, and fetches the extension words. It then presents one complete, byte-order-corrected instruction bundle to the decoder under a valid/stall handshake. Control-flow changes (jumps, calls, returns) redirect it through a PC load port.

## Interface

Parameters:
- `RESET_PC`, default 16'hC000: PC value loaded on reset.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `pc_load`  input  1  redirect request from the execute side.
- `pc_load_val`  input  16  redirect target; bit 0 forced to 0.
- `stall`  input  1  decoder not ready; holds the current bundle.
- `MDB_out`  input  16  ROM read data for the address on `MAB_out`; combinational, same cycle, low byte first.
- `MAB_out`  output  16  ROM read address; always equals `reg_PC_out`.
- `reg_PC_out`  output  16  current fetch PC.
- `instr_valid`  output  1  bundle complete and held.
- `instr`  output  16  opcode word, byte-swapped: {MDB[7:0],MDB[15:8]}.
- `ext1`, `ext2`  output  16 each  first/second extension words, byte-swapped the same way; 0 when unused.
- `instr_len`  output  2  bundle length in words (1, 2 or 3).
- `instr_addr`  output  16  address of the opcode word.

## Operation

- States: FETCH_OP, FETCH_EXT1, FETCH_EXT2, HOLD.
- FETCH_OP:
  - Captures the swapped word into `instr`, sets `instr_addr` to PC, clears `ext1`/`ext2`, latches the computed length, and sets PC to PC+2.
  - Next state is HOLD if length is 1, otherwise FETCH_EXT1.
- FETCH_EXT1: captures `ext1`, PC to PC+2. Next state is FETCH_EXT2 if length is 3, otherwise HOLD.
- FETCH_EXT2: captures `ext2`, PC to PC+2, next state HOLD.
- HOLD:
  - `instr_valid` is 1 and PC does not advance.
  - A bundle is consumed on a rising edge where `instr_valid` is 1 and `stall` is 0; the next state is then FETCH_OP.
  - While `stall` is 1, all outputs hold.
- Length rules, all on the swapped word:
  - Format is jump when [15:13]=001, Format II when [15:12]=0001, Format I when [15:12]≥0100. Any other encoding is length 1.
  - Source extension word (Format I: As=[5:4], src=[11:8]; Format II: As=[5:4], reg=[3:0]) is needed when:
    - As=01 and src≠3 (indexed, symbolic, absolute), or
    - As=11 and src=0 (immediate).
  - No source word for the constant generator cases: src=3 with any As, or src=2 with As=1x.
  - Destination extension word: Format I with Ad=[7]=1.
  - Length = 1 + source word + destination word.
  - When both words are present, `ext1` holds the source word and `ext2` the destination word.
- Redirect:
  - `pc_load`=1 in any state has top priority.
  - PC is set to {pc_load_val[15:1],0}, the next state is FETCH_OP, and any partial or held bundle is discarded.
  - `instr_valid` is 0 from the following cycle.
  - If `pc_load` coincides with a consuming edge in HOLD, the bundle counts as consumed and the redirect still applies.
- PC arithmetic is 16-bit modulo: 16'hFFFE + 2 = 16'h0000.

## Timing

- Reset values:
  - PC, `MAB_out` and `reg_PC_out` = `RESET_PC`.
  - `instr_valid`, `instr`, `ext1`, `ext2` and `instr_addr` = 0.
  - `instr_len` = 1.
  - State = FETCH_OP.
- Reset asserted mid-bundle aborts immediately (asynchronous); the first fetch after release is from `RESET_PC`.
- Latency from entering FETCH_OP to `instr_valid`=1 is `instr_len` cycles. Back-to-back throughput is `instr_len`+1 cycles per instruction.
- All outputs are registered except `MAB_out` and `reg_PC_out`, which are the PC register itself.
- `instr_valid` and the bundle fields are stable from the rising edge that enters HOLD until the consuming edge, so the decoder's negedge latch sees stable data.
- `stall` is sampled only in HOLD and ignored in every other state.

## Test plan

- Reset, then ROM[0xC000]=0x0645 (MOV R5,R6), `stall`=0 -> one cycle later `instr`=0x4506, `instr_len`=1, `instr_addr`=0xC000, `instr_valid`=1. After the consume edge, PC=0xC002 and the state is FETCH_OP.
- ROM holds 0x3640 then 0x3412 (MOV #0x1234,R6) -> `instr`=0x4036, `ext1`=0x1234, `ext2`=0, `instr_len`=2, valid after 2 cycles, PC advanced by 4.
- ROM holds 0x9242, 0x0002, 0x0202 (MOV &0x0200,&0x0202) -> `instr_len`=3, `ext1`=0x0200, `ext2`=0x0202. A 0x1643 (MOV #1,R6 via the constant generator) -> `instr_len`=1. A 0x003C (JMP) -> `instr_len`=1.
- Hold `stall`=1 for 5 cycles in HOLD -> all outputs unchanged and PC frozen. Release -> next opcode fetched on the following cycle.
- Assert `pc_load`=1 with `pc_load_val`=0xE001 during FETCH_EXT1 -> PC=0xE000, `instr_valid` stays 0, and the next bundle comes from 0xE000. Separately, `pc_load` on the consume edge -> the held bundle is consumed exactly once.
- Opcode at 0xFFFE with length 2 -> the extension word is read from 0x0000 and PC ends at 0x0002. Assert `rst` during FETCH_EXT1 -> immediate return to the reset values.
